// File: rtl/inertial_intf_if.sv
// inertial_intf_if: SPI monarch command/response handshake between sequencer and monarch.
interface inertial_intf_if;
    logic        snd;
    logic        done;
    logic [15:0] cmd;
    logic [15:0] resp;
    modport master (output snd, cmd, input done, resp);
    modport slave (input snd, cmd, output done, resp);
endinterface

// File: rtl/inertial_intf.sv
// inertial_intf: gyro power-up wait, configuration writes, then INT-driven yaw-rate reads over SPI.
module inertial_intf #(
    parameter int TMR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    inertial_intf_if.master    spi,
    output logic [15:0]        yaw_rt,
    output logic               vld
);
    typedef enum logic [2:0] {PWR_WAIT, WAIT_C1, WAIT_C2, WAIT_C3, IDLE, WAIT_L, WAIT_H} state_t;
    state_t state, nxt_state;
    logic [TMR_W-1:0] tmr;
    logic [7:0] lo, nxt_lo;
    logic [15:0] nxt_cmd, nxt_yaw;
    logic int_ff, int_s, nxt_snd, nxt_vld, ack;
    // the previous transaction's done is still high during the snd cycle
    assign ack = spi.done & ~spi.snd;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= PWR_WAIT;
            tmr     <= '0;
            int_ff  <= 1'b0;
            int_s   <= 1'b0;
            lo      <= 8'h00;
            spi.snd <= 1'b0;
            spi.cmd <= 16'h0000;
            yaw_rt  <= 16'h0000;
            vld     <= 1'b0;
        end else begin
            state   <= nxt_state;
            tmr     <= (state == PWR_WAIT) ? tmr + TMR_W'(1) : tmr;
            int_ff  <= INT;
            int_s   <= int_ff;
            lo      <= nxt_lo;
            spi.snd <= nxt_snd;
            spi.cmd <= nxt_cmd;
            yaw_rt  <= nxt_yaw;
            vld     <= nxt_vld;
        end
    always_comb begin
        nxt_state = state;
        nxt_snd   = 1'b0;
        nxt_cmd   = spi.cmd;
        nxt_yaw   = yaw_rt;
        nxt_vld   = 1'b0;
        nxt_lo    = lo;
        case (state)
            PWR_WAIT: if (&tmr) begin
                nxt_snd   = 1'b1;
                nxt_cmd   = 16'h0D02;
                nxt_state = WAIT_C1;
            end
            WAIT_C1: if (ack) begin
                nxt_snd   = 1'b1;
                nxt_cmd   = 16'h1160;
                nxt_state = WAIT_C2;
            end
            WAIT_C2: if (ack) begin
                nxt_snd   = 1'b1;
                nxt_cmd   = 16'h1440;
                nxt_state = WAIT_C3;
            end
            WAIT_C3: if (ack) nxt_state = IDLE;
            IDLE: if (int_s) begin
                nxt_snd   = 1'b1;
                nxt_cmd   = 16'hA600;
                nxt_state = WAIT_L;
            end
            WAIT_L: if (ack) begin
                nxt_lo    = spi.resp[7:0];
                nxt_snd   = 1'b1;
                nxt_cmd   = 16'hA700;
                nxt_state = WAIT_H;
            end
            WAIT_H: if (ack) begin
                nxt_yaw   = {spi.resp[7:0], lo};
                nxt_vld   = 1'b1;
                nxt_state = IDLE;
            end
            default: nxt_state = PWR_WAIT;
        endcase
    end
endmodule

// File: tb/tb_inertial_intf.sv
// tb_inertial_intf: SPI monarch/gyro responder model plus event queues checked against expected command flow.
module tb_inertial_intf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic INT = 1'b0;
    logic [15:0] yaw_rt;
    logic vld;
    logic [7:0] lo_val = 8'h00, hi_val = 8'h00;
    int checks = 0, fails = 0, cyc = 0;
    bit prev_snd = 1'b0;
    logic [15:0] snd_cmd_q[$], vld_yaw_q[$];
    int snd_cyc_q[$], vld_cyc_q[$], done_cyc_q[$];

    inertial_intf_if ifc();
    inertial_intf #(.TMR_W(4)) dut (.clk(clk), .rst_n(rst_n), .INT(INT), .spi(ifc), .yaw_rt(yaw_rt), .vld(vld));

    always #5 clk = ~clk;
    always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

    // SPI monarch + gyro: accept snd on the following edge, answer after a random latency
    initial begin
        logic [15:0] c, r;
        ifc.done = 1'b0;
        ifc.resp = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && ifc.snd) begin
                c = ifc.cmd;
                @(posedge clk);
                #1 ifc.done = 1'b0;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1;
                r = 16'($urandom);
                if (c == 16'hA600) r[7:0] = lo_val;
                if (c == 16'hA700) r[7:0] = hi_val;
                ifc.resp = r;
                ifc.done = 1'b1;
                done_cyc_q.push_back(cyc);
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (ifc.snd) begin
            checks++;
            if (prev_snd) begin fails++; $display("FAIL snd_width cyc=%0d snd high two cycles, required one", cyc); end
            snd_cmd_q.push_back(ifc.cmd);
            snd_cyc_q.push_back(cyc);
        end
        if (vld) begin
            checks++;
            if (ifc.snd) begin fails++; $display("FAIL vld_with_snd cyc=%0d snd=1 required 0", cyc); end
            vld_yaw_q.push_back(yaw_rt);
            vld_cyc_q.push_back(cyc);
        end
        prev_snd = ifc.snd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic wait_snd(output logic [15:0] c, output int t);
        int n = 0;
        while (snd_cmd_q.size() == 0 && n < 300) begin @(negedge clk); n++; end
        if (snd_cmd_q.size() != 0) begin c = snd_cmd_q.pop_front(); t = snd_cyc_q.pop_front(); end
        else begin c = 'x; t = -1; end
    endtask

    task automatic wait_vld(output logic [15:0] y, output int t);
        int n = 0;
        while (vld_yaw_q.size() == 0 && n < 300) begin @(negedge clk); n++; end
        if (vld_yaw_q.size() != 0) begin y = vld_yaw_q.pop_front(); t = vld_cyc_q.pop_front(); end
        else begin y = 'x; t = -1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (12) @(posedge clk);
        snd_cmd_q.delete(); snd_cyc_q.delete(); vld_yaw_q.delete(); vld_cyc_q.delete(); done_cyc_q.delete();
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ifc.snd !== 1'b0) begin fails++; $display("FAIL reset_snd got=%b exp=0", ifc.snd); end
        checks++; if (ifc.cmd !== 16'h0000) begin fails++; $display("FAIL reset_cmd got=%h exp=0000", ifc.cmd); end
        checks++; if (yaw_rt !== 16'h0000) begin fails++; $display("FAIL reset_yaw got=%h exp=0000", yaw_rt); end
        checks++; if (vld !== 1'b0) begin fails++; $display("FAIL reset_vld got=%b exp=0", vld); end
        do_reset();
    endtask

    task automatic test_config(input string tag, input bit quiet_check);
        logic [15:0] c;
        int t, exp_t, n;
        logic [15:0] exp_cmd [3] = '{16'h0D02, 16'h1160, 16'h1440};
        for (int k = 0; k < 3; k++) begin
            wait_snd(c, t);
            exp_t = (k == 0) ? 16 : done_cyc_q[k-1] + 1;
            checks++; if (c !== exp_cmd[k]) begin fails++; $display("FAIL %s cfg_cmd%0d got=%h exp=%h", tag, k, c, exp_cmd[k]); end
            checks++; if (t !== exp_t) begin fails++; $display("FAIL %s cfg_cyc%0d got=%0d exp=%0d", tag, k, t, exp_t); end
        end
        n = 0;
        while (done_cyc_q.size() < 3 && n < 300) begin @(negedge clk); n++; end
        if (quiet_check) begin
            repeat (30) @(negedge clk);
            checks++; if (snd_cmd_q.size() !== 0) begin fails++; $display("FAIL %s idle_snd got=%0d extra snd exp=0", tag, snd_cmd_q.size()); end
        end
    endtask

    task automatic test_read(input logic [7:0] lo, input logic [7:0] hi);
        logic [15:0] c, y;
        int t, t0;
        lo_val = lo;
        hi_val = hi;
        @(posedge clk);
        #1 INT = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 INT = 1'b0;
        wait_snd(c, t);
        checks++; if (c !== 16'hA600) begin fails++; $display("FAIL read_lo_cmd got=%h exp=A600", c); end
        checks++; if (t !== t0 + 3) begin fails++; $display("FAIL int_latency got=%0d exp=%0d", t, t0 + 3); end
        wait_snd(c, t);
        checks++; if (c !== 16'hA700) begin fails++; $display("FAIL read_hi_cmd got=%h exp=A700", c); end
        checks++; if (t !== done_cyc_q[$] + 1) begin fails++; $display("FAIL read_hi_cyc got=%0d exp=%0d", t, done_cyc_q[$] + 1); end
        wait_vld(y, t);
        checks++; if (y !== {hi, lo}) begin fails++; $display("FAIL read_yaw got=%h exp=%h", y, {hi, lo}); end
        checks++; if (t !== done_cyc_q[$] + 1) begin fails++; $display("FAIL read_vld_cyc got=%0d exp=%0d", t, done_cyc_q[$] + 1); end
        repeat (20) @(negedge clk);
        checks++; if (yaw_rt !== {hi, lo}) begin fails++; $display("FAIL yaw_hold got=%h exp=%h", yaw_rt, {hi, lo}); end
        checks++;
        if (vld_yaw_q.size() + snd_cmd_q.size() !== 0) begin
            fails++; $display("FAIL read_extra got=%0d extra events exp=0", vld_yaw_q.size() + snd_cmd_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c, y;
        int t, tv;
        lo_val = 8'hF0;
        hi_val = 8'hFF;
        INT = 1'b1;
        do_reset();
        test_config("early", 1'b0);
        wait_snd(c, t);
        checks++; if (c !== 16'hA600) begin fails++; $display("FAIL early_first_read got=%h exp=A600", c); end
        checks++; if (t !== done_cyc_q[2] + 2) begin fails++; $display("FAIL early_first_cyc got=%0d exp=%0d", t, done_cyc_q[2] + 2); end
        for (int k = 0; k < 3; k++) begin
            wait_snd(c, t);
            checks++; if (c !== 16'hA700) begin fails++; $display("FAIL b2b_hi_cmd%0d got=%h exp=A700", k, c); end
            wait_vld(y, tv);
            checks++; if (y !== 16'hFFF0) begin fails++; $display("FAIL b2b_yaw%0d got=%h exp=FFF0", k, y); end
            wait_snd(c, t);
            checks++; if (c !== 16'hA600) begin fails++; $display("FAIL b2b_lo_cmd%0d got=%h exp=A600", k, c); end
            checks++; if (t !== tv + 1) begin fails++; $display("FAIL b2b_restart%0d got=%0d exp=%0d", k, t, tv + 1); end
        end
        INT = 1'b0;
        repeat (40) @(negedge clk);
        snd_cmd_q.delete(); snd_cyc_q.delete(); vld_yaw_q.delete(); vld_cyc_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [15:0] c;
        int t;
        lo_val = 8'(($urandom));
        hi_val = 8'(($urandom));
        @(posedge clk);
        #1 INT = 1'b1;
        @(posedge clk);
        #1 INT = 1'b0;
        wait_snd(c, t);
        checks++; if (c !== 16'hA600) begin fails++; $display("FAIL mid_lo_cmd got=%h exp=A600", c); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ifc.snd !== 1'b0) begin fails++; $display("FAIL mid_rst_snd got=%b exp=0", ifc.snd); end
        checks++; if (vld !== 1'b0) begin fails++; $display("FAIL mid_rst_vld got=%b exp=0", vld); end
        checks++; if (yaw_rt !== 16'h0000) begin fails++; $display("FAIL mid_rst_yaw got=%h exp=0000", yaw_rt); end
        do_reset();
        test_config("rerun", 1'b1);
    endtask

    initial begin
        test_reset();
        test_config("cfg", 1'b1);
        test_read(8'h34, 8'h12);
        for (int i = 0; i < 3; i++) test_read(8'($urandom), 8'($urandom));
        test_back_to_back();
        test_reset_mid();
        test_read(8'($urandom), 8'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/inertial_intf.md
Name: inertial_intf

Overview:
- Command/response sequencer that sits directly upstream of the SPI monarch and drives its snd/cmd inputs.
- After reset it waits for the gyro to power up, then issues the three-word gyro configuration sequence.
- It then services every data-ready interrupt (INT) by reading the yaw-rate low and high bytes over SPI.
- Each completed read publishes a 16-bit yaw rate with a one-cycle valid strobe to the downstream integrator.

Parameters:
- TMR_W, 16, width of the power-up wait counter; the wait lasts 2^TMR_W clocks (benches use 4).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- INT  input  1  gyro data-ready interrupt; asynchronous, level, active-high
- done  input  1  SPI transaction complete; level from the SPI monarch, cleared by the edge that accepts snd
- resp  input  16  SPI receive word; valid while done=1
- snd  output  1  one-clock start pulse to the SPI monarch
- cmd  output  16  SPI command word; valid in the snd cycle and held until the next snd
- yaw_rt  output  16  latest yaw rate, {high byte, low byte}, two's complement
- vld  output  1  one-clock strobe: yaw_rt updated

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk):
  - snd=0, cmd=16'h0000, yaw_rt=16'h0000, vld=0.
  - Timer cleared, INT synchronizers cleared, FSM to PWR_WAIT.
- Outputs snd, cmd, yaw_rt and vld are all registered.
- INT passes through a two-flop synchronizer; only the second flop (INT_s) is used.
- Handshake guard: done is honoured only in a WAIT_* state and only in a cycle where snd=0. The stale done=1 from the previous transaction is therefore ignored in the snd cycle.
- FSM states and transitions:
  - PWR_WAIT: the TMR_W-bit timer increments every clock. When timer is all ones, register snd=1, cmd=16'h0D02 (enable INT on data-ready); go to WAIT_C1.
  - WAIT_C1: on done -> snd=1, cmd=16'h1160 (gyro ODR/range); go to WAIT_C2.
  - WAIT_C2: on done -> snd=1, cmd=16'h1440 (rounding enable); go to WAIT_C3.
  - WAIT_C3: on done -> go to IDLE.
  - IDLE: on INT_s=1 -> snd=1, cmd=16'hA600 (read yaw low); go to WAIT_L.
  - WAIT_L: on done -> capture resp[7:0] into a low-byte holding register; snd=1, cmd=16'hA700 (read yaw high); go to WAIT_H.
  - WAIT_H: on done -> yaw_rt <= {resp[7:0], low-byte register}; vld=1 for exactly one clock; go to IDLE.
- snd is high for exactly one clock per command; no second snd is issued before done is honoured.
- INT is level-sensitive:
  - INT during PWR_WAIT or WAIT_C* is ignored (not queued).
  - If INT_s is still 1 on return to IDLE, the next read starts on the first IDLE cycle.
- Latency:
  - First snd is asserted at clock 2^TMR_W after reset release.
  - vld follows the honoured done of the high-byte read by one edge.
  - INT rise to snd is 3 clocks: 2 synchronizer edges plus 1 registered-output edge.
- yaw_rt holds its value between vld strobes. vld never coincides with snd.
- Reset mid-transaction: all state is discarded and the full power-up and configuration sequence reruns. yaw_rt returns to 0.
- An unused state encoding goes to PWR_WAIT.

Test Plan:
- Reset, TMR_W=4, SPI monarch plus a gyro responder, INT held 0 -> first snd at clock 16 with cmd=16'h0D02, then 16'h1160, then 16'h1440, each snd one clock wide and spaced by a full SPI transaction; no further snd while INT=0.
- After configuration, pulse INT high; responder returns 8'h34 for A6 and 8'h12 for A7 -> cmd 16'hA600 then 16'hA700; a single vld with yaw_rt=16'h1234; yaw_rt stable afterwards.
- Stale done: done held at 1 from the prior transaction in the snd cycle -> FSM stays in its WAIT state; exactly one command per transaction; no skipped command.
- INT asserted throughout PWR_WAIT and configuration -> no A6 read before 16'h1440 completes; first A600 issued on the first IDLE cycle.
- Negative value: responses 8'hF0 (low) and 8'hFF (high) -> yaw_rt=16'hFFF0; INT held high continuously -> back-to-back reads with one vld per read.
- rst_n pulsed low during WAIT_L -> snd=0, vld=0, yaw_rt=0 immediately; after release, the full 16-clock wait and the three configuration commands repeat.
